// File: rtl/matmul_tile_sequencer_pkg.sv
// Shared definitions for the matmul tile sequencer: FSM states, ALU opcodes and tile geometry.
package matmul_tile_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StWait,
        StStore,
        StDone
    } state_e;

    localparam logic [15:0] INSTR_NOP    = 16'd0;
    localparam logic [15:0] INSTR_MATMUL = 16'd1;

    localparam int unsigned WORDS_PER_TILE = 8;
    localparam int unsigned RES_PER_TILE   = 4;

endpackage

// File: rtl/matmul_tile_sequencer.sv
// Feeds 2x2 operand tiles from weight memory to the ALU, pulses matmul, and writes
// the four products to result memory, for NUM_TILES tiles per start.
module matmul_tile_sequencer
    import matmul_tile_sequencer_pkg::*;
#(
    parameter int unsigned NUM_TILES  = 8,
    parameter int unsigned DW         = 32,
    parameter int unsigned SRC_AW     = 6,
    parameter int unsigned RES_AW     = 5,
    parameter int unsigned RESULT_LAT = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         src_rd_en,
    output logic [SRC_AW-1:0]            src_rd_addr,
    input  logic [DW-1:0]                src_rd_data,
    output logic [15:0]                  ID_instr,
    output logic [DW-1:0]                matrixA_11,
    output logic [DW-1:0]                matrixA_12,
    output logic [DW-1:0]                matrixA_21,
    output logic [DW-1:0]                matrixA_22,
    output logic [DW-1:0]                matrixB_11,
    output logic [DW-1:0]                matrixB_12,
    output logic [DW-1:0]                matrixB_21,
    output logic [DW-1:0]                matrixB_22,
    input  logic [DW-1:0]                matrixp00,
    input  logic [DW-1:0]                matrixp01,
    input  logic [DW-1:0]                matrixp10,
    input  logic [DW-1:0]                matrixp11,
    output logic                         res_wr_en,
    output logic [RES_AW-1:0]            res_wr_addr,
    output logic [DW-1:0]                res_wr_data,
    output logic [$clog2(NUM_TILES):0]   tile_idx
);

    localparam int unsigned TW = $clog2(NUM_TILES) + 1;
    localparam int unsigned CW = $clog2(RESULT_LAT + WORDS_PER_TILE + 1);
    localparam logic [CW-1:0] FETCH_LAST = CW'(WORDS_PER_TILE);
    localparam logic [CW-1:0] WAIT_LAST  = CW'(RESULT_LAT - 1);
    localparam logic [CW-1:0] STORE_LAST = CW'(RES_PER_TILE - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   tile_q, tile_d;
    logic [DW-1:0]   opnd_q [WORDS_PER_TILE];
    logic [DW-1:0]   snap_q [RES_PER_TILE];
    logic [2:0]      opnd_idx;
    logic            last_tile;

    // Read data lags the strobe by one cycle, so count f lands in operand slot f-1.
    assign opnd_idx  = 3'(cnt_q - CW'(1));
    assign last_tile = (tile_q == TW'(NUM_TILES - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tile_d      = tile_q;
        busy        = (state_q != StIdle);
        done        = 1'b0;
        src_rd_en   = 1'b0;
        src_rd_addr = '0;
        ID_instr    = INSTR_NOP;
        res_wr_en   = 1'b0;
        res_wr_addr = '0;
        res_wr_data = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                    cnt_d   = '0;
                    tile_d  = '0;
                end
            end
            StFetch: begin
                if (cnt_q != FETCH_LAST) begin
                    src_rd_en   = 1'b1;
                    src_rd_addr = SRC_AW'(tile_q) * SRC_AW'(WORDS_PER_TILE) + SRC_AW'(cnt_q);
                    cnt_d       = cnt_q + CW'(1);
                end else begin
                    state_d = StIssue;
                    cnt_d   = '0;
                end
            end
            StIssue: begin
                ID_instr = INSTR_MATMUL;
                state_d  = StWait;
                cnt_d    = '0;
            end
            StWait: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = StStore;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StStore: begin
                res_wr_en   = 1'b1;
                res_wr_addr = RES_AW'(tile_q) * RES_AW'(RES_PER_TILE) + RES_AW'(cnt_q);
                res_wr_data = snap_q[cnt_q[1:0]];
                if (cnt_q == STORE_LAST) begin
                    cnt_d   = '0;
                    tile_d  = tile_q + TW'(1);
                    state_d = last_tile ? StDone : StFetch;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            tile_q  <= '0;
            for (int i = 0; i < WORDS_PER_TILE; i++) opnd_q[i] <= '0;
            for (int i = 0; i < RES_PER_TILE; i++) snap_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tile_q  <= tile_d;
            if (state_q == StFetch && cnt_q != '0) begin
                opnd_q[opnd_idx] <= src_rd_data;
            end
            if (state_q == StWait && cnt_q == WAIT_LAST) begin
                snap_q[0] <= matrixp00;
                snap_q[1] <= matrixp01;
                snap_q[2] <= matrixp10;
                snap_q[3] <= matrixp11;
            end
        end
    end

    assign tile_idx   = tile_q;
    assign matrixA_11 = opnd_q[0];
    assign matrixA_12 = opnd_q[1];
    assign matrixA_21 = opnd_q[2];
    assign matrixA_22 = opnd_q[3];
    assign matrixB_11 = opnd_q[4];
    assign matrixB_12 = opnd_q[5];
    assign matrixB_21 = opnd_q[6];
    assign matrixB_22 = opnd_q[7];

endmodule

// File: doc/matmul_tile_sequencer.md
Name: matmul_tile_sequencer

Overview:
Upstream feeder and downstream collector for single_cycle_alu. It reads 2x2 operand tiles (8 words: A11,A12,A21,A22,B11,B12,B21,B22) from a synchronous weight memory and drives them onto the ALU operand inputs. It then pulses the matmul instruction for one cycle, snapshots the four product words and writes them to a result memory. It repeats for NUM_TILES tiles per start, replacing the hand-sequenced bench stimulus.

Parameters:
NUM_TILES, 8, tiles processed per start; weight memory holds NUM_TILES*8 words
DW, 32, element width
SRC_AW, 6, weight-memory address width; must satisfy 2**SRC_AW >= NUM_TILES*8
RES_AW, 5, result-memory address width; must satisfy 2**RES_AW >= NUM_TILES*4
RESULT_LAT, 1, cycles from instruction pulse to valid ALU products; legal range >= 1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a run; sampled only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last result write
src_rd_en  out  1  weight-memory read strobe
src_rd_addr  out  SRC_AW  weight-memory read address
src_rd_data  in  DW  read data, valid the cycle after src_rd_en
ID_instr  out  16  ALU instruction: 16'd1 = matmul for one cycle, else 16'd0
matrixA_11, matrixA_12, matrixA_21, matrixA_22  out  DW each  A operands to ALU
matrixB_11, matrixB_12, matrixB_21, matrixB_22  out  DW each  B operands to ALU
matrixp00, matrixp01, matrixp10, matrixp11  in  DW each  ALU products
res_wr_en  out  1  result-memory write strobe
res_wr_addr  out  RES_AW  result write address
res_wr_data  out  DW  result write data
tile_idx  out  $clog2(NUM_TILES)+1  index of the current tile; holds NUM_TILES after done

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE. The operand registers and result snapshot registers also clear to 0.
- State machine: IDLE -> FETCH -> ISSUE -> WAIT -> STORE -> (FETCH | DONE) -> IDLE.
- IDLE: if start=1, go to FETCH at the next edge with tile_idx=0. start=0 stays in IDLE.
- FETCH: lasts 9 cycles, f=0..8.
  - For f=0..7: src_rd_en=1 and src_rd_addr=tile_idx*8+f.
  - For f=1..8: src_rd_data is captured into operand register f-1, in the order A11,A12,A21,A22,B11,B12,B21,B22.
  - src_rd_en=0 at f=8.
- Operand outputs are registers. They change only during FETCH captures and are held stable at all other times.
- ISSUE: exactly 1 cycle with ID_instr=16'd1. ID_instr=16'd0 in every other cycle.
- WAIT: lasts RESULT_LAT cycles. At the edge ending the final WAIT cycle, snapshot matrixp00..p11.
- STORE: lasts 4 cycles, k=0..3.
  - res_wr_en=1, res_wr_addr=tile_idx*4+k.
  - res_wr_data = snapshot of p00, p01, p10, p11 in that order.
- After STORE: tile_idx increments.
  - If the new tile_idx < NUM_TILES, go to FETCH.
  - Otherwise go to DONE.
- DONE: 1 cycle with done=1, then IDLE.
- busy is low in IDLE only. It is high on the cycle after start is accepted and stays high through the DONE cycle.
- Timing: each tile takes 14+RESULT_LAT cycles. With defaults, a run is 8*15=120 cycles plus 1 DONE cycle.
- start while busy is ignored and has no effect on the running sequence.
- Reset mid-operation: asserting rst_n=0 in any state forces IDLE and zeros all outputs immediately (asynchronously). Writes in flight are abandoned, and there is no done pulse.
- Address arithmetic is unsigned. No wrap-around occurs within legal parameters.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, FETCH, ISSUE, WAIT, STORE, DONE);
  - INSTR_NOP=16'd0 and INSTR_MATMUL=16'd1;
  - WORDS_PER_TILE=8 and RES_PER_TILE=4.
- Single module; no sub-module is needed. The operand register bank stays inline as an 8-entry array indexed by f-1.

Test Plan:
1. Reset: hold rst_n=0 for 200 ns -> all outputs 0, busy=0, ID_instr=0.
2. NUM_TILES=1; memory words 0..7 = 1,0,0,1,2,3,4,5; stub ALU with registered outputs and 1-cycle latency.
   - Expect ID_instr=1 exactly at cycle 10 after start is accepted.
   - Expect writes at addresses 0..3 with data 2,3,4,5.
   - Expect done at cycle 16.
3. Default 8-tile run with memory words 0..63 random:
   - Expect 32 writes at addresses 0..31 in order, each matching the reference 2x2 product.
   - Expect done exactly 121 cycles after start is accepted and tile_idx=8.
4. Pulse start during tile 2 FETCH -> no restart, identical write sequence, a single done.
5. Drop rst_n in the STORE k=1 cycle of tile 3 -> outputs 0 immediately, no further writes, no done; a new start then replays from tile 0.
6. RESULT_LAT=3 with an ALU stub of 3-cycle latency -> correct products, 17 cycles per tile.
